intersection_sequencer: RTL and testbench
=========================================

# intersection_sequencer

Timed phase sequencer for the four-street intersection. It drives the per-street light codes through green, yellow and all-red clearance, and rotates right-of-way Street1→Street2→Street3→Street4 in normal operation. Emergency-vehicle requests preempt that rotation through a req/ack handshake, with round-robin arbitration among competing streets. It replaces hard state jumps with a dwell-timed, clearance-safe schedule and sits between the emergency sensor front-end and the lamp drivers.

## Interface
- GREEN_CYC, 8: normal green dwell, cycles.
- MIN_GREEN, 2: minimum green before an emergency elsewhere may cut it short.
- YELLOW_CYC, 3: yellow dwell, cycles.
- ALLRED_CYC, 2: all-red clearance, cycles.
- CNT_W, 8: dwell counter width.
- Legal values: all dwell parameters ≥1; MIN_GREEN ≤ GREEN_CYC; every dwell value < 2^CNT_W.

- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- emg_req  in  4  emergency request, bit i = Street(i+1); level, held until acked and served.
- emg_ack  out  4  one-hot or zero; bit i high while Street(i+1) holds green for its emergency.
- phase  out  2  index of the street currently owning (or last owning) right-of-way.
- Street1..Street4  out  2 each  lamp code: 2'b00 red, 2'b01 yellow, 2'b11 green.

## Operation
- Reset, at the first clk edge with reset=1:
  - state=ALLRED, elapsed=0, phase=0, last_emg=3.
  - All streets 00; emg_ack=0.
- States: GREEN, YELLOW, ALLRED. `elapsed` counts cycles spent in the current state, starting at 0 and saturating at 2^CNT_W−1.
- GREEN: Street(phase+1)=11, all others 00.
  - hold = emg_req[phase]. While hold, stay in GREEN; emg_ack[phase]=1.
  - Exit to YELLOW when !hold and either of:
    - elapsed ≥ GREEN_CYC−1; or
    - any emg_req[j≠phase] is set and elapsed ≥ MIN_GREEN−1.
  - A hold running past GREEN_CYC exits the cycle after the req drops.
  - Another street's request never interrupts an active hold.
- YELLOW: Street(phase+1)=01. Exit to ALLRED after YELLOW_CYC cycles.
- ALLRED: all streets 00. After ALLRED_CYC cycles, go to GREEN with the next phase chosen by the decision below.
- Next-phase decision, taken on the last ALLRED cycle:
  - If any emg_req bit is set: grant the first set bit scanning from (last_emg+1) mod 4 upward, wrapping around. phase := grant; last_emg := grant.
  - Otherwise: phase := (phase+1) mod 4.
- A request withdrawn before the decision cycle has no effect.
- A request on the street that is already green is served as a hold. It does not restart the cycle.
- emg_ack is combinational on state, phase and emg_req, so it drops in the same cycle the req drops.

## Timing
- Normal green is exactly GREEN_CYC cycles; normal period is 4·(GREEN_CYC+YELLOW_CYC+ALLRED_CYC).
- Preempt latency:
  - Request seen at elapsed e in a foreign green: YELLOW begins at cycle max(e, MIN_GREEN−1)+1.
  - The requested green then begins YELLOW_CYC+ALLRED_CYC cycles later.
- Hold release: YELLOW on the first edge after the req is sampled low.
- Reset mid-operation, any state: next cycle all red, ack 0, phase 0; Street1 green after ALLRED_CYC cycles.
- Lamp outputs are registered state decoded combinationally. There is never a cycle with two non-red streets, and never a cycle with a direct green→green change.

## Configuration
- INTERSECTION_EMG_PREEMPT_EN
  - Defined: emergency preemption, holds and arbitration as above.
  - Undefined: emg_req ignored; emg_ack tied 0; last_emg removed; pure fixed rotation. Ports are unchanged.

## Structure
- Shared package tlc_pkg holds:
  - the light-code constants LIGHT_RED / LIGHT_YELLOW / LIGHT_GREEN;
  - the state encoding (GREEN/YELLOW/ALLRED);
  - the street count NUM_STREETS=4.
- One sub-module, rr_arbiter4: combinational round-robin over 4 requests given a 2-bit last-grant pointer. Outputs a grant index and a valid flag.

## Test plan
- Default params, no requests:
  - Reset released at cycle 0: Street1 11 cycles 2–9, 01 cycles 10–12, all-red 13–14, Street2 11 at cycle 15.
  - Period 52 cycles.
- emg_req=4'b0100 asserted at Street1 green elapsed 0:
  - Street1 green cycles 2–3, then yellow.
  - Street3 green at cycle 9 (Street2 skipped); emg_ack=4'b0100.
- Hold emg_req[2] for 20 cycles of Street3 green: green stays 11, ack stays high. Drop the req: yellow on the next cycle, then Street4 green.
- emg_req=4'b1010 at decision with last_emg=2: Street4 granted first. Keep req[1] set: Street2 is granted at the following decision.
- Reset pulsed during yellow: next cycle all 00, ack 0, phase 0; Street1 green two cycles after reset falls.
- Macro undefined, emg_req=4'b1111 held: rotation and timing identical to the first scenario; emg_ack stays 0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the intersection sequencer: lamp codes, state encoding, street count.
package tlc_pkg;

  localparam int NUM_STREETS = 4;

  localparam logic [1:0] LIGHT_RED    = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_GREEN  = 2'b11;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    ALLRED = 2'd2
  } tlc_state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin arbiter over four requests; the scan starts one past the last grant.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant,
  output logic       valid
);

  logic [7:0] dbl_s;
  logic [2:0] start_s;
  logic [3:0] rot_s;
  logic [1:0] off_s;

  // Rotate the request vector so bit 0 is the first candidate, then priority-encode
  always_comb begin
    dbl_s   = {req, req};
    start_s = {1'b0, last} + 3'd1;
    rot_s   = dbl_s[start_s +: 4];
    off_s   = 2'd0;
    valid   = 1'b1;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        off_s = 2'd0;
        valid = 1'b0;
      end
    endcase
    grant = last + 2'd1 + off_s;
  end

endmodule

// File: rtl/intersection_sequencer.sv
// Four-street green/yellow/all-red sequencer with optional emergency preemption.
// Preemption, holds and round-robin arbitration are built only when INTERSECTION_EMG_PREEMPT_EN is defined.
module intersection_sequencer
  import tlc_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int MIN_GREEN  = 2,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] emg_req,
  output logic [3:0] emg_ack,
  output logic [1:0] phase,
  output logic [1:0] Street1,
  output logic [1:0] Street2,
  output logic [1:0] Street3,
  output logic [1:0] Street4
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  tlc_state_e       state_r;
  logic [CNT_W-1:0] elapsed_r;
  logic [CNT_W-1:0] elapsed_inc_s;
  logic [1:0]       phase_r;
  logic             init_r;
  logic             hold_s;
  logic             foreign_s;
  logic             green_exit_s;
  logic             decide_s;
  logic [1:0]       next_phase_s;
  logic [1:0]       lamps_s [NUM_STREETS];

  assign elapsed_inc_s = (elapsed_r == CNT_MAX) ? elapsed_r : elapsed_r + CNT_W'(1);
  assign decide_s      = (state_r == ALLRED) && (elapsed_r >= ALLRED_LAST);
  assign green_exit_s  = !hold_s &&
                         ((elapsed_r >= GREEN_LAST) || (foreign_s && (elapsed_r >= MIN_LAST)));

`ifdef INTERSECTION_EMG_PREEMPT_EN
  logic [1:0] last_emg_r;
  logic [1:0] grant_s;
  logic       grant_vld_s;

  rr_arbiter4 u_arb (
    .req   (emg_req),
    .last  (last_emg_r),
    .grant (grant_s),
    .valid (grant_vld_s)
  );

  assign hold_s    = emg_req[phase_r];
  assign foreign_s = |(emg_req & ~(4'b0001 << phase_r));

  // Emergency grant wins the decision; the first decision after reset always lands on Street1
  always_comb begin
    if (grant_vld_s) begin
      next_phase_s = grant_s;
    end else if (init_r) begin
      next_phase_s = 2'd0;
    end else begin
      next_phase_s = phase_r + 2'd1;
    end
  end

  // Acknowledge only while the requesting street actually holds green
  always_comb begin
    if ((state_r == GREEN) && emg_req[phase_r]) begin
      emg_ack = 4'b0001 << phase_r;
    end else begin
      emg_ack = 4'b0000;
    end
  end

  // Round-robin pointer, moved only when an emergency grant is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      last_emg_r <= 2'd3;
    end else if (decide_s && grant_vld_s) begin
      last_emg_r <= grant_s;
    end else begin
      last_emg_r <= last_emg_r;
    end
  end
`else
  logic emg_req_unused_s;

  assign emg_req_unused_s = ^emg_req;
  assign hold_s           = 1'b0;
  assign foreign_s        = 1'b0;
  assign emg_ack          = 4'b0000;

  // Fixed rotation; the first decision after reset lands on Street1
  always_comb begin
    if (init_r) begin
      next_phase_s = 2'd0;
    end else begin
      next_phase_s = phase_r + 2'd1;
    end
  end
`endif

  // Phase state machine with saturating dwell counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ALLRED;
      elapsed_r <= '0;
      phase_r   <= 2'd0;
      init_r    <= 1'b1;
    end else begin
      case (state_r)
        GREEN: begin
          if (green_exit_s) begin
            state_r   <= YELLOW;
            elapsed_r <= '0;
          end else begin
            elapsed_r <= elapsed_inc_s;
          end
        end
        YELLOW: begin
          if (elapsed_r >= YELLOW_LAST) begin
            state_r   <= ALLRED;
            elapsed_r <= '0;
          end else begin
            elapsed_r <= elapsed_inc_s;
          end
        end
        ALLRED: begin
          if (decide_s) begin
            state_r   <= GREEN;
            elapsed_r <= '0;
            phase_r   <= next_phase_s;
            init_r    <= 1'b0;
          end else begin
            elapsed_r <= elapsed_inc_s;
          end
        end
        default: begin
          state_r   <= ALLRED;
          elapsed_r <= '0;
        end
      endcase
    end
  end

  // Lamp decode: only the owning street may show a non-red code
  always_comb begin
    for (int i = 0; i < NUM_STREETS; i++) begin
      lamps_s[i] = LIGHT_RED;
    end
    case (state_r)
      GREEN:   lamps_s[phase_r] = LIGHT_GREEN;
      YELLOW:  lamps_s[phase_r] = LIGHT_YELLOW;
      ALLRED:  lamps_s[phase_r] = LIGHT_RED;
      default: lamps_s[phase_r] = LIGHT_RED;
    endcase
  end

  assign Street1 = lamps_s[0];
  assign Street2 = lamps_s[1];
  assign Street3 = lamps_s[2];
  assign Street4 = lamps_s[3];
  assign phase   = phase_r;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Scoreboard bench for intersection_sequencer: stimulus queues hand-computed per-cycle outputs, a negedge monitor compares.
module tb_intersection_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] emg_req;
  logic [3:0] emg_ack;
  logic [1:0] phase;
  logic [1:0] Street1, Street2, Street3, Street4;

  typedef struct {
    logic [13:0] v;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  intersection_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .emg_req (emg_req),
    .emg_ack (emg_ack),
    .phase   (phase),
    .Street1 (Street1),
    .Street2 (Street2),
    .Street3 (Street3),
    .Street4 (Street4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {Street1..Street4, emg_ack, phase}
  function automatic logic [13:0] mk(input logic [1:0] ph, input logic [1:0] code, input logic [3:0] ack);
    logic [7:0] l;
    l = 8'h00;
    case (ph)
      2'd0:    l[7:6] = code;
      2'd1:    l[5:4] = code;
      2'd2:    l[3:2] = code;
      default: l[1:0] = code;
    endcase
    return {l, ack, ph};
  endfunction

  task automatic cyc(input logic r, input logic [3:0] q, input logic [1:0] ph, input logic [1:0] code,
                     input logic [3:0] ack, input string tag, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    reset   = r;
    emg_req = q;
    if (chk) begin
      e.v   = mk(ph, code, ack);
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic green(input logic [1:0] ph, input int n, input logic [3:0] q, input logic [3:0] ack, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, q, ph, 2'b11, ack, tag, 1'b1);
  endtask

  task automatic yellow(input logic [1:0] ph, input int n, input logic [3:0] q, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, q, ph, 2'b01, 4'b0000, tag, 1'b1);
  endtask

  task automatic allred(input logic [1:0] ph, input int n, input logic [3:0] q, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, q, ph, 2'b00, 4'b0000, tag, 1'b1);
  endtask

  // One full normal rotation starting at Street1 green: 4 x (8 + 3 + 2) = 52 cycles
  task automatic period(input logic [3:0] q, input string tag);
    for (int s = 0; s < 4; s++) begin
      green(2'(s), 8, q, 4'b0000, tag);
      yellow(2'(s), 3, q, tag);
      allred(2'(s), 2, q, tag);
    end
  endtask

  // Monitor: compare every cycle that has a queued expectation
  always @(negedge clk) begin
    exp_t        e;
    logic [13:0] got;
    if (exp_q.size() != 0) begin
      e     = exp_q.pop_front();
      got   = {Street1, Street2, Street3, Street4, emg_ack, phase};
      total = total + 1;
      if (got !== e.v) begin
        bad = bad + 1;
        $display("FAIL %s t=%0t got lamps=%b ack=%b phase=%0d want lamps=%b ack=%b phase=%0d",
                 e.tag, $time, got[13:6], got[5:2], got[1:0], e.v[13:6], e.v[5:2], e.v[1:0]);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    emg_req = 4'b0000;
    cyc(1'b1, 4'b0000, 2'd0, 2'b00, 4'b0000, "pre_reset", 1'b0);
    allred(2'd0, 2, 4'b0000, "reset_state");
    period(4'b0000, "rotation");

`ifdef INTERSECTION_EMG_PREEMPT_EN
    period(4'b0000, "rotation2");
    green(2'd0, 2, 4'b0100, 4'b0000, "preempt_min_green");
    yellow(2'd0, 3, 4'b0100, "preempt_yellow");
    allred(2'd0, 2, 4'b0100, "preempt_allred");
    green(2'd2, 20, 4'b0100, 4'b0100, "hold_green");
    green(2'd2, 1, 4'b0000, 4'b0000, "hold_drop");
    yellow(2'd2, 3, 4'b0000, "hold_release_yellow");
    allred(2'd2, 2, 4'b0000, "hold_allred");
    green(2'd3, 8, 4'b0000, 4'b0000, "resume_rotation");
    yellow(2'd3, 3, 4'b0000, "resume_yellow");
    allred(2'd3, 1, 4'b0000, "arb_allred");
    allred(2'd3, 1, 4'b1010, "arb_decision");
    green(2'd3, 2, 4'b1010, 4'b1000, "arb_grant_st4");
    green(2'd3, 1, 4'b0010, 4'b0000, "arb_st4_release");
    yellow(2'd3, 3, 4'b0010, "arb_yellow");
    allred(2'd3, 2, 4'b0010, "arb_allred2");
    green(2'd1, 1, 4'b0010, 4'b0010, "arb_grant_st2");
    green(2'd1, 7, 4'b0000, 4'b0000, "arb_st2_normal");
    yellow(2'd1, 3, 4'b0000, "arb_st2_yellow");
    allred(2'd1, 2, 4'b0000, "arb_st2_allred");
    green(2'd2, 8, 4'b0000, 4'b0000, "post_arb_rotation");
    yellow(2'd2, 1, 4'b0000, "pre_reset_yellow");
    cyc(1'b1, 4'b0000, 2'd2, 2'b01, 4'b0000, "reset_cycle_yellow", 1'b1);
`else
    period(4'b1111, "ignored_req_rotation");
    green(2'd0, 8, 4'b1111, 4'b0000, "ignored_req_green");
    yellow(2'd0, 3, 4'b0000, "yellow3");
    allred(2'd0, 2, 4'b0000, "allred3");
    green(2'd1, 8, 4'b0000, 4'b0000, "green3");
    yellow(2'd1, 1, 4'b0000, "pre_reset_yellow");
    cyc(1'b1, 4'b0000, 2'd1, 2'b01, 4'b0000, "reset_cycle_yellow", 1'b1);
`endif

    allred(2'd0, 2, 4'b0000, "mid_reset_allred");
    green(2'd0, 3, 4'b0000, 4'b0000, "mid_reset_st1_green");

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
